data_line: RTL and testbench

DATA_LINE -- requirements
Module: data_line

---
 rtl/dpc_pkg.sv | 37 +++
 rtl/bcd_updown.sv | 59 +++++
 rtl/data_line.sv | 154 +++++++++++++++
 tb/tb_data_line.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpc_pkg.sv
// dpc_pkg: constants, opcodes, FSM states and BCD helpers shared by the
// data line and its bench.
package dpc_pkg;

    localparam int unsigned CELLS_DEFAULT  = 100;
    localparam int unsigned DIGITS_DEFAULT = 3;

    // Opcodes carried on the instruction line; anything else is a NOP here.
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_HALT  = 4'h1,
        OP_INC   = 4'h2,
        OP_DEC   = 4'h3,
        OP_RIGHT = 4'h4,
        OP_LEFT  = 4'h5
    } opcode_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_EXEC,
        ST_MOVE,
        ST_FETCH,
        ST_HALTED
    } state_t;

    // Two-digit BCD pointer to binary cell index.
    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    // Binary 0..99 to two-digit BCD.
    function automatic logic [7:0] bin2bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_updown.sv
// bcd_updown: combinational N-digit BCD increment/decrement with wrap.
//   value     : current BCD value
//   max_value : largest legal value; up from it wraps to 0, down from 0 wraps to it
//   up        : 1 = +1, 0 = -1
//   result    : stepped value
module bcd_updown #(
    parameter int unsigned DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic [4*DIGITS-1:0] max_value,
    input  logic                up,
    output logic [4*DIGITS-1:0] result
);

    logic [4*DIGITS-1:0] step;
    logic                carry;
    logic [3:0]          d;
    logic [3:0]          nd;

    // Carry/borrow ripples from the least significant digit upward.
    always_comb begin
        step  = '0;
        carry = 1'b1;
        d     = '0;
        nd    = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d  = value[4*i +: 4];
            nd = d;
            if (carry) begin
                if (up) begin
                    if (d == 4'd9) begin
                        nd = 4'd0;
                    end else begin
                        nd    = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        nd = 4'd9;
                    end else begin
                        nd    = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            step[4*i +: 4] = nd;
        end
    end

    always_comb begin
        if (up && (value == max_value))
            result = '0;
        else if (!up && (value == '0))
            result = max_value;
        else
            result = step;
    end

endmodule

// File: rtl/data_line.sv
// data_line: BCD data tape with a cell pointer, driven one opcode at a time.
//   Clk, Rst     : clock, synchronous active-high reset
//   Request/Insn : one-cycle request strobe with its opcode
//   Ready        : one-cycle completion pulse
//   Busy         : high whenever the FSM is not IDLE
//   Halt         : sticky halt flag, cleared only by Rst
//   ApAddress    : current cell pointer (two BCD digits)
//   Data         : current cell value (DIGITS BCD digits)
//   dataIsZeroed : Data == 0
module data_line
    import dpc_pkg::*;
#(
    parameter int unsigned CELLS  = CELLS_DEFAULT,
    parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Request,
    input  logic [3:0]          Insn,
    output logic                Ready,
    output logic                Busy,
    output logic                Halt,
    output logic [7:0]          ApAddress,
    output logic [4*DIGITS-1:0] Data,
    output logic                dataIsZeroed
);

    localparam int unsigned W         = 4 * DIGITS;
    localparam int unsigned ADDR_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [7:0]  LAST_ADDR = bin2bcd(CELLS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                dir_up;
    logic [W-1:0]        data_step;
    logic [7:0]          addr_step;

    logic [W-1:0]        mem [CELLS];
    logic [W-1:0]        rd_data;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [W-1:0]        wdata;
    logic [ADDR_W-1:0]   raddr;

    bcd_updown #(.DIGITS(DIGITS)) u_data_step (
        .value     (Data),
        .max_value ({DIGITS{4'd9}}),
        .up        (dir_up),
        .result    (data_step)
    );

    bcd_updown #(.DIGITS(2)) u_addr_step (
        .value     (ApAddress),
        .max_value (LAST_ADDR),
        .up        (dir_up),
        .result    (addr_step)
    );

    // The read address is the pointer's next value, so the read issued in
    // MOVE lands in rd_data in time for FETCH.
    assign raddr = ADDR_W'(bcd2bin(addr_step));

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (!Rst) begin
            case (state)
                ST_CLEAR: begin
                    we    = 1'b1;
                    waddr = clr_cnt;
                end
                ST_EXEC: begin
                    we    = 1'b1;
                    waddr = ADDR_W'(bcd2bin(ApAddress));
                    wdata = data_step;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_data <= mem[raddr];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            ApAddress <= '0;
            Data      <= '0;
            Ready     <= 1'b0;
            Halt      <= 1'b0;
            dir_up    <= 1'b0;
        end else begin
            Ready <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == ADDR_W'(CELLS - 1)) begin
                        clr_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Blocking acceptance while Ready is high keeps a new
                    // request from coinciding with the previous pulse.
                    if (Request && !Ready) begin
                        case (Insn)
                            OP_HALT: begin
                                Halt  <= 1'b1;
                                Ready <= 1'b1;
                                state <= ST_HALTED;
                            end
                            OP_INC, OP_DEC: begin
                                dir_up <= (Insn == OP_INC);
                                state  <= ST_EXEC;
                            end
                            OP_RIGHT, OP_LEFT: begin
                                dir_up <= (Insn == OP_RIGHT);
                                state  <= ST_MOVE;
                            end
                            default: Ready <= 1'b1;
                        endcase
                    end
                end
                ST_EXEC: begin
                    Data  <= data_step;
                    Ready <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_MOVE: begin
                    ApAddress <= addr_step;
                    state     <= ST_FETCH;
                end
                ST_FETCH: begin
                    Data  <= rd_data;
                    Ready <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_CLEAR;
            endcase
        end
    end

    assign Busy         = (state != ST_IDLE);
    assign dataIsZeroed = (Data == '0);

endmodule

// File: tb/tb_data_line.sv
module tb_data_line;
    import dpc_pkg::*;

    localparam int NCELLS = 100;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Request = 1'b0;
    logic [3:0]  Insn = 4'h0;
    logic        Ready;
    logic        Busy;
    logic        Halt;
    logic [7:0]  ApAddress;
    logic [11:0] Data;
    logic        dataIsZeroed;

    data_line #(.CELLS(NCELLS), .DIGITS(3)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Request      (Request),
        .Insn         (Insn),
        .Ready        (Ready),
        .Busy         (Busy),
        .Halt         (Halt),
        .ApAddress    (ApAddress),
        .Data         (Data),
        .dataIsZeroed (dataIsZeroed)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference tape kept in plain binary.
    int m_mem [NCELLS];
    int m_ptr    = 0;
    bit m_halted = 0;

    typedef struct {
        int data;
        int addr;
        int lat;
        int t0;
    } exp_t;

    exp_t sb [$];

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("ready_unexpected", 32'(Ready), 32'h0);
            end else begin
                e = sb.pop_front();
                check_val("ready_latency", 32'(cyc - e.t0), 32'(e.lat));
                check_val("ready_data", 32'(Data), to_bcd(e.data));
                check_val("ready_addr", 32'(ApAddress), to_bcd(e.addr));
                check_val("ready_zero", 32'(dataIsZeroed), 32'(e.data == 0));
            end
        end
    end

    // Drive one request; extra_at > 0 pulses a second (to-be-ignored)
    // request that many cycles later.
    task automatic run_op(input logic [3:0] op, input int extra_at);
        exp_t e;
        int   lat;
        @(negedge Clk);
        Request = 1'b1;
        Insn    = op;
        if (!m_halted) begin
            case (op)
                OP_INC:   begin m_mem[m_ptr] = (m_mem[m_ptr] + 1) % 1000;   lat = 2; end
                OP_DEC:   begin m_mem[m_ptr] = (m_mem[m_ptr] + 999) % 1000; lat = 2; end
                OP_RIGHT: begin m_ptr = (m_ptr + 1) % NCELLS;               lat = 3; end
                OP_LEFT:  begin m_ptr = (m_ptr + NCELLS - 1) % NCELLS;      lat = 3; end
                default:  lat = 1;
            endcase
            e.data = m_mem[m_ptr];
            e.addr = m_ptr;
            e.lat  = lat;
            e.t0   = cyc;
            sb.push_back(e);
            if (op == OP_HALT)
                m_halted = 1;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            Request = (extra_at != 0) && (k == extra_at);
            if (k >= 4 && sb.size() == 0)
                break;
        end
        Request = 1'b0;
        if (sb.size() != 0) begin
            check_val("ready_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
    endtask

    // Called at a negedge; asserts Rst there and runs the full clear.
    task automatic do_reset();
        int cnt;
        Rst     = 1'b1;
        Request = 1'b0;
        repeat (3) @(negedge Clk);
        check_val("rst_addr", 32'(ApAddress), 32'h0);
        check_val("rst_data", 32'(Data), 32'h0);
        check_val("rst_ready", 32'(Ready), 32'h0);
        check_val("rst_halt", 32'(Halt), 32'h0);
        check_val("rst_busy", 32'(Busy), 32'h1);
        Rst = 1'b0;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge Clk);
        end
        check_val("clear_cycles", 32'(cnt), 32'(NCELLS));
        check_val("idle_data", 32'(Data), 32'h0);
        check_val("idle_zero", 32'(dataIsZeroed), 32'h1);
        check_val("idle_addr", 32'(ApAddress), 32'h0);
        foreach (m_mem[i]) m_mem[i] = 0;
        m_ptr    = 0;
        m_halted = 0;
    endtask

    initial begin
        @(negedge Clk);
        do_reset();

        // Basic arithmetic and digit wrap.
        repeat (3) run_op(OP_INC, 0);
        run_op(OP_DEC, 0);
        check_val("data_002", 32'(Data), 32'h002);
        repeat (2) run_op(OP_DEC, 0);
        run_op(OP_DEC, 0);
        check_val("data_999", 32'(Data), 32'h999);
        run_op(OP_INC, 0);
        check_val("data_wrap0", 32'(Data), 32'h000);
        repeat (5) run_op(OP_INC, 0);

        // Pointer movement and pointer wrap.
        run_op(OP_RIGHT, 0);
        run_op(OP_INC, 0);
        run_op(OP_LEFT, 0);
        check_val("back_addr", 32'(ApAddress), 32'h00);
        check_val("back_data", 32'(Data), 32'h005);
        run_op(OP_LEFT, 0);
        check_val("left_wrap", 32'(ApAddress), 32'h99);
        run_op(OP_INC, 0);
        run_op(OP_RIGHT, 0);
        check_val("right_wrap", 32'(ApAddress), 32'h00);

        // NOP and an unassigned opcode.
        run_op(OP_NOP, 0);
        run_op(4'hA, 0);

        // Requests while busy are dropped.
        run_op(OP_INC, 1);
        run_op(OP_RIGHT, 2);
        run_op(OP_LEFT, 0);
        check_val("busy_ign_data", 32'(Data), 32'h006);

        // Halt is sticky and blocks further requests.
        run_op(OP_HALT, 0);
        check_val("halt_set", 32'(Halt), 32'h1);
        check_val("halt_busy", 32'(Busy), 32'h1);
        run_op(OP_INC, 0);
        repeat (4) @(negedge Clk);
        check_val("halt_data", 32'(Data), 32'h006);
        check_val("halt_sticky", 32'(Halt), 32'h1);

        @(negedge Clk);
        do_reset();
        run_op(OP_RIGHT, 0);
        run_op(OP_LEFT, 0);
        run_op(OP_LEFT, 0);
        run_op(OP_INC, 0);
        run_op(OP_LEFT, 0);

        // Reset landing on the FETCH cycle of a RIGHT.
        @(negedge Clk);
        Request = 1'b1;
        Insn    = OP_RIGHT;
        @(negedge Clk);
        Request = 1'b0;
        @(negedge Clk);
        do_reset();
        run_op(OP_LEFT, 0);
        check_val("post_abort_99", 32'(Data), 32'h000);

        repeat (3) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
